// File: rtl/alu_control_mc.sv
// ALU control decode plus a multi-cycle radix-2 multiply/divide engine with HI/LO registers.
// Define ALU_CTRL_DIV_EN to build the restoring divider (DIV/DIVU); without it they decode as illegal.
module alu_control_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod, step_prod, prod_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mcand, a_mag, b_mag, res_hi, res_lo;
    logic               is_mul, is_div, is_mf, is_signed, a_neg, b_neg, start;
    logic               op_div, neg_q;
`ifdef ALU_CTRL_DIV_EN
    logic               neg_r, div_zero;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   quot, rem;
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        alu_ctrl = 4'b0000;
        illegal  = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        is_mf    = 1'b0;
        case (ALUOp)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b11: alu_ctrl = 4'b0000;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_ctrl = 4'b0010;
                    6'b100010, 6'b100011: alu_ctrl = 4'b0110;
                    6'b100100:            alu_ctrl = 4'b0000;
                    6'b100101:            alu_ctrl = 4'b0001;
                    6'b100111:            alu_ctrl = 4'b1100;
                    6'b101010:            alu_ctrl = 4'b0111;
                    6'b101011:            alu_ctrl = 4'b1000;
                    6'b010000, 6'b010010: begin
                        alu_ctrl = 4'b1110;
                        is_mf    = 1'b1;
                    end
                    6'b011000, 6'b011001: is_mul = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    6'b011010, 6'b011011: is_div = 1'b1;
`endif
                    default:              illegal = 1'b1;
                endcase
            end
        endcase
    end

    // MULT and DIV have funct[0]=0; the unsigned variants have funct[0]=1.
    assign is_signed = ~funct[0];
    assign a_neg     = is_signed & src_a[WIDTH-1];
    assign b_neg     = is_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;
    assign start     = valid & (is_mul | is_div) & ~busy;
    assign stall     = busy & valid & (is_mul | is_div | is_mf);
    assign hilo_rd   = (ALUOp == 2'b10 && funct == 6'b010000) ? hi : lo;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply keeps accumulator:multiplier in prod; divide keeps remainder:quotient.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        step_prod = {mul_sum, prod[WIDTH-1:1]};
`ifdef ALU_CTRL_DIV_EN
        r_shift  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff = {1'b0, r_shift} - {2'b00, mcand};
        if (op_div) begin
            if (div_diff[WIDTH+1])
                step_prod = {r_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
            else
                step_prod = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        prod_fix = neg_q ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
`ifdef ALU_CTRL_DIV_EN
        // A zero divisor leaves quotient all ones and remainder = |dividend|, so only LO needs forcing.
        quot = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem  = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        if (op_div) begin
            res_hi = rem;
            res_lo = div_zero ? '1 : quot;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            prod     <= '0;
            mcand    <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    prod   <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                    mcand  <= is_div ? b_mag : a_mag;
                    op_div <= is_div;
                    neg_q  <= a_neg ^ b_neg;
`ifdef ALU_CTRL_DIV_EN
                    neg_r    <= a_neg;
                    div_zero <= (src_b == '0);
`endif
                    count  <= CW'(WIDTH);
                    busy   <= 1'b1;
                end
                RUN: begin
                    prod  <= step_prod;
                    count <= count - CW'(1);
                end
                FINISH: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode table plus multiply/divide, stall, and reset sequences.
module tb_alu_control_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   alu_ctrl;
    logic         illegal, stall, busy, done;
    logic [W-1:0] hilo_rd, hi, lo;

    int checks = 0;
    int errors = 0;

    alu_control_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ALUOp(ALUOp), .funct(funct),
        .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .stall(stall), .busy(busy), .done(done), .hilo_rd(hilo_rd), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
                           F_ADD = 6'b100000;
`ifdef ALU_CTRL_DIV_EN
    localparam logic DIV_ILL = 1'b0;
`else
    localparam logic DIV_ILL = 1'b1;
`endif

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
    } dec_vec_t;

    dec_vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid = 1'b1;
        ALUOp = 2'b10;
        funct = f;
        src_a = a;
        src_b = b;
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        ALUOp = 2'b00;
        funct = 6'b000000;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h1234_5678;
    endtask

    // Waits for done after the start edge; returns the number of edges taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!done && cycles < 100);
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int cyc;
        issue(f, a, b);
        #1;
        check({name, " start no stall"}, 64'(stall), 64'd0);
        step();
        idle_inputs();
        check({name, " busy after start"}, 64'(busy), 64'd1);
        wait_done(cyc);
        check({name, " latency"}, 64'(cyc), 64'(W + 1));
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        check({name, " busy cleared"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] old_hi, old_lo;

        vecs.push_back('{2'b11, 6'b111111, 4'b0000, 1'b0});
        vecs.push_back('{2'b00, 6'b100010, 4'b0010, 1'b0});
        vecs.push_back('{2'b01, 6'b000000, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b100000, 4'b0010, 1'b0});
        vecs.push_back('{2'b10, 6'b100001, 4'b0010, 1'b0});
        vecs.push_back('{2'b10, 6'b100100, 4'b0000, 1'b0});
        vecs.push_back('{2'b10, 6'b100010, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b100011, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 6'b100101, 4'b0001, 1'b0});
        vecs.push_back('{2'b10, 6'b100111, 4'b1100, 1'b0});
        vecs.push_back('{2'b10, 6'b101010, 4'b0111, 1'b0});
        vecs.push_back('{2'b10, 6'b101011, 4'b1000, 1'b0});
        vecs.push_back('{2'b10, F_MFHI,    4'b1110, 1'b0});
        vecs.push_back('{2'b10, F_MFLO,    4'b1110, 1'b0});
        vecs.push_back('{2'b10, F_MULT,    4'b0000, 1'b0});
        vecs.push_back('{2'b10, F_MULTU,   4'b0000, 1'b0});
        vecs.push_back('{2'b10, F_DIV,     4'b0000, DIV_ILL});
        vecs.push_back('{2'b10, F_DIVU,    4'b0000, DIV_ILL});
        vecs.push_back('{2'b10, 6'b111111, 4'b0000, 1'b1});

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        foreach (vecs[i]) begin
            ALUOp = vecs[i].op;
            funct = vecs[i].fn;
            #1;
            check($sformatf("decode[%0d] ctrl", i), 64'(alu_ctrl), 64'(vecs[i].ctrl));
            check($sformatf("decode[%0d] illegal", i), 64'(illegal), 64'(vecs[i].ill));
        end
        step();
        idle_inputs();

        run_op("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu ffffffff*2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
`ifdef ALU_CTRL_DIV_EN
        run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu 7/0", F_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
        old_hi = hi;
        old_lo = lo;
        issue(F_DIV, 32'd100, 32'd3);
        #1;
        check("nodiv illegal", 64'(illegal), 64'd1);
        check("nodiv ctrl", 64'(alu_ctrl), 64'd0);
        step();
        idle_inputs();
        check("nodiv busy", 64'(busy), 64'd0);
        step();
        check("nodiv hi", 64'(hi), 64'(old_hi));
        check("nodiv lo", 64'(lo), 64'(old_lo));
`endif

        // Independent op flows, MFLO stalls until FINISH then reads the new LO.
        old_lo = lo;
        issue(F_MULT, 32'd3, 32'd5);
        step();
        issue(F_ADD, 32'd1, 32'd1);
        #1;
        check("add while busy stall", 64'(stall), 64'd0);
        issue(F_MFLO, 32'd0, 32'd0);
        #1;
        check("mflo stalls", 64'(stall), 64'd1);
        check("mflo old value", 64'(hilo_rd), 64'(old_lo));
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (stall && cyc < 100);
        check("mflo stall length", 64'(cyc), 64'(W + 1));
        check("mflo new value", 64'(hilo_rd), 64'd15);
        issue(F_MFHI, 32'd0, 32'd0);
        #1;
        check("mfhi value", 64'(hilo_rd), 64'd0);
        idle_inputs();

        // Mult presented in the FINISH cycle waits one cycle, then starts.
        issue(F_MULTU, 32'd4, 32'd5);
        step();
        idle_inputs();
        repeat (W) step();
        issue(F_MULT, 32'd2, 32'd3);
        #1;
        check("finish busy", 64'(busy), 64'd1);
        check("finish stall", 64'(stall), 64'd1);
        step();
        check("finish done", 64'(done), 64'd1);
        check("finish lo", 64'(lo), 64'd20);
        check("post-finish stall", 64'(stall), 64'd0);
        step();
        idle_inputs();
        check("restart busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("restart latency", 64'(cyc), 64'(W + 1));
        check("restart lo", 64'(lo), 64'd6);

        // Reset during RUN aborts the op; done never pulses afterwards.
        issue(F_MULTU, 32'd9, 32'd9);
        step();
        idle_inputs();
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        cyc = 0;
        repeat (W + 8) begin
            step();
            if (done) cyc++;
        end
        check("abort no done", 64'(cyc), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
